// File: rtl/alu_fp_pkg.sv
// -----------------------------------------------------------------------------
// alu_fp_pkg
// Shared definitions for the floating-point ALU blocks (alu_div, and later
// alu_mult): IEEE-754 single-precision field widths, exponent bias, the
// all-ones exponent code, the canonical quiet NaN, a packed operand view and
// the divider FSM state encoding.
// -----------------------------------------------------------------------------
package alu_fp_pkg;

    localparam int FP_EXP_W  = 8;
    localparam int FP_MANT_W = 23;
    localparam int FP_BIAS   = 127;

    localparam logic [FP_EXP_W-1:0] EXP_MAX = '1;
    localparam logic [31:0]         QNAN    = 32'h7FC0_0000;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_MANT_W-1:0] mant;
    } fp32_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIV   = 2'd1,
        ROUND = 2'd2
    } div_state_e;

endpackage

// File: rtl/alu_fp_classify.sv
// -----------------------------------------------------------------------------
// alu_fp_classify
// Combinational decode of one floating-point operand. Subnormals (exponent
// field 0) are reported as zero so the datapath flushes them.
//
// Ports:
//   op_i       in   operand {sign, exp, mant}
//   sign_o     out  sign bit
//   exp_o      out  biased exponent field
//   is_zero_o  out  exponent field is 0 (zero or flushed subnormal)
//   is_inf_o   out  exponent all ones, mantissa 0
//   is_nan_o   out  exponent all ones, mantissa nonzero
//   mant_o     out  mantissa with the hidden 1 prepended
// -----------------------------------------------------------------------------
module alu_fp_classify #(
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 23
) (
    input  logic [EXP_WIDTH+MANT_WIDTH:0] op_i,
    output logic                          sign_o,
    output logic [EXP_WIDTH-1:0]          exp_o,
    output logic                          is_zero_o,
    output logic                          is_inf_o,
    output logic                          is_nan_o,
    output logic [MANT_WIDTH:0]           mant_o
);

    logic [MANT_WIDTH-1:0] frac;
    logic                  exp_ones;

    assign sign_o    = op_i[EXP_WIDTH+MANT_WIDTH];
    assign exp_o     = op_i[EXP_WIDTH+MANT_WIDTH-1:MANT_WIDTH];
    assign frac      = op_i[MANT_WIDTH-1:0];
    assign exp_ones  = &exp_o;

    assign is_zero_o = ~|exp_o;
    assign is_inf_o  = exp_ones & ~|frac;
    assign is_nan_o  = exp_ones & |frac;
    assign mant_o    = {1'b1, frac};

endmodule

// File: rtl/alu_div.sv
// -----------------------------------------------------------------------------
// alu_div
// Sequential IEEE-754 single-precision divider, dataR = dataA / dataB.
// Radix-2 restoring division (26 quotient bits), round-to-nearest-even,
// subnormals flushed to signed zero. Special operands resolve in one cycle
// without leaving IDLE; normal operands take 28 cycles from accept to done.
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   request, accepted only while busy=0
//   dataA  in   dividend, sampled on the accepting edge
//   dataB  in   divisor, sampled on the accepting edge
//   busy   out  division iterations / rounding in progress
//   done   out  one-cycle pulse, dataR valid from this cycle
//   dataR  out  result, held until the next done
//   flags  out  {invalid, divzero, overflow}; only when ALU_DIV_FLAGS_EN
//
// Build option: define ALU_DIV_FLAGS_EN to add the flags port.
// -----------------------------------------------------------------------------
module alu_div
    import alu_fp_pkg::*;
#(
    parameter int EXP_WIDTH  = FP_EXP_W,
    parameter int MANT_WIDTH = FP_MANT_W,
    parameter int BIAS       = FP_BIAS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [EXP_WIDTH+MANT_WIDTH:0] dataA,
    input  logic [EXP_WIDTH+MANT_WIDTH:0] dataB,
    output logic                          busy,
    output logic                          done,
    output logic [EXP_WIDTH+MANT_WIDTH:0] dataR
`ifdef ALU_DIV_FLAGS_EN
    ,
    output logic [2:0]                    flags
`endif
);

    localparam int FP_W = 1 + EXP_WIDTH + MANT_WIDTH;
    localparam int MW   = MANT_WIDTH + 1;   // mantissa incl. hidden bit
    localparam int QW   = MANT_WIDTH + 3;   // quotient bits (24 + guard + sticky)
    localparam int RW   = MANT_WIDTH + 2;   // partial remainder
    localparam int EW   = EXP_WIDTH + 2;    // signed exponent working width
    localparam int CW   = $clog2(QW);

    localparam logic [EXP_WIDTH-1:0]  EMAX_F = '1;
    localparam logic [FP_W-1:0]       QNAN_L = {1'b0, EMAX_F, 1'b1, {(MANT_WIDTH-1){1'b0}}};
    localparam logic signed [EW-1:0]  E_ZERO = '0;
    localparam logic signed [EW-1:0]  E_ONE  = EW'(1);
    localparam logic signed [EW-1:0]  E_MAX  = EW'((1 << EXP_WIDTH) - 1);
    localparam logic signed [EW-1:0]  BIAS_E = EW'(BIAS);

    // Normalize the raw quotient, round to nearest even, then range-check.
    // e_in already carries ea - eb + BIAS (the q[MSB]=1 case).
    function automatic logic [FP_W-1:0] round_pack(
        input logic                   s,
        input logic [QW-1:0]          q,
        input logic                   rem_nz,
        input logic signed [EW-1:0]   e_in
    );
        logic [MW-1:0]         m;
        logic [MW:0]           mr;
        logic                  g;
        logic                  st;
        logic signed [EW-1:0]  e;
        if (q[QW-1]) begin
            m  = q[QW-1:2];
            g  = q[1];
            st = q[0] | rem_nz;
            e  = e_in;
        end else begin
            m  = q[QW-2:1];
            g  = q[0];
            st = rem_nz;
            e  = e_in - E_ONE;
        end
        mr = {1'b0, m} + {{MW{1'b0}}, g & (st | m[0])};
        if (mr[MW]) begin
            m = {1'b1, {(MW-1){1'b0}}};
            e = e + E_ONE;
        end else begin
            m = mr[MW-1:0];
        end
        if (e >= E_MAX)
            round_pack = {s, EMAX_F, {MANT_WIDTH{1'b0}}};
        else if (e <= E_ZERO)
            round_pack = {s, {(FP_W-1){1'b0}}};
        else
            round_pack = {s, e[EXP_WIDTH-1:0], m[MW-2:0]};
    endfunction

    // ---- operand decode ----
    logic                 sa, sb, za, zb, ia, ib, na, nb;
    logic [EXP_WIDTH-1:0] ea, eb;
    logic [MW-1:0]        ma, mb;

    alu_fp_classify #(.EXP_WIDTH(EXP_WIDTH), .MANT_WIDTH(MANT_WIDTH)) u_cls_a (
        .op_i(dataA), .sign_o(sa), .exp_o(ea), .is_zero_o(za),
        .is_inf_o(ia), .is_nan_o(na), .mant_o(ma)
    );

    alu_fp_classify #(.EXP_WIDTH(EXP_WIDTH), .MANT_WIDTH(MANT_WIDTH)) u_cls_b (
        .op_i(dataB), .sign_o(sb), .exp_o(eb), .is_zero_o(zb),
        .is_inf_o(ib), .is_nan_o(nb), .mant_o(mb)
    );

    logic sign_r;
    assign sign_r = sa ^ sb;

    // Special operand combinations produce their result directly at accept.
    logic            spec_hit;
    logic [FP_W-1:0] spec_res;

    always_comb begin
        spec_hit = 1'b1;
        spec_res = '0;
        if (na | nb | (za & zb) | (ia & ib))
            spec_res = QNAN_L;
        else if (ia | zb)
            spec_res = {sign_r, EMAX_F, {MANT_WIDTH{1'b0}}};
        else if (za | ib)
            spec_res = {sign_r, {(FP_W-1){1'b0}}};
        else
            spec_hit = 1'b0;
    end

    // ---- state and datapath registers ----
    div_state_e             state_q, state_d;
    logic                   done_q, done_d;
    logic [FP_W-1:0]        dataR_q, dataR_d;
    logic [RW-1:0]          rem_q, rem_d;
    logic [QW-1:0]          q_q, q_d;
    logic [MW-1:0]          mb_q, mb_d;
    logic signed [EW-1:0]   e_q, e_d;
    logic                   sr_q, sr_d;
    logic [CW-1:0]          cnt_q, cnt_d;

    // One restoring step: trial subtract, keep if non-negative, then shift.
    logic            rem_ge;
    logic [RW-1:0]   rem_sub;
    logic [FP_W-1:0] rnd_res;

    assign rem_ge  = rem_q >= {1'b0, mb_q};
    assign rem_sub = rem_ge ? (rem_q - {1'b0, mb_q}) : rem_q;
    assign rnd_res = round_pack(sr_q, q_q, |rem_q, e_q);

`ifdef ALU_DIV_FLAGS_EN
    logic [2:0] flags_q, flags_d;
    logic       spec_inv, spec_dz, ovf;
    assign spec_inv = na | nb | (za & zb) | (ia & ib);
    assign spec_dz  = zb & ~za & ~ia & ~na & ~nb;
    // Within ROUND an all-ones exponent can only come from overflow.
    assign ovf      = &rnd_res[FP_W-2:MANT_WIDTH];
`endif

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        dataR_d = dataR_q;
        rem_d   = rem_q;
        q_d     = q_q;
        mb_d    = mb_q;
        e_d     = e_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
`ifdef ALU_DIV_FLAGS_EN
        flags_d = flags_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (spec_hit) begin
                        dataR_d = spec_res;
                        done_d  = 1'b1;
`ifdef ALU_DIV_FLAGS_EN
                        flags_d = {spec_inv, spec_dz, 1'b0};
`endif
                    end else begin
                        rem_d   = {1'b0, ma};
                        q_d     = '0;
                        mb_d    = mb;
                        e_d     = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_E;
                        sr_d    = sign_r;
                        cnt_d   = CW'(QW - 1);
                        state_d = DIV;
                    end
                end
            end
            DIV: begin
                q_d   = {q_q[QW-2:0], rem_ge};
                rem_d = {rem_sub[RW-2:0], 1'b0};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0)
                    state_d = ROUND;
            end
            ROUND: begin
                dataR_d = rnd_res;
                done_d  = 1'b1;
                state_d = IDLE;
`ifdef ALU_DIV_FLAGS_EN
                flags_d = {2'b00, ovf};
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // ---- control / result register stage ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            dataR_q <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            dataR_q <= dataR_d;
        end
    end

`ifdef ALU_DIV_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst)
            flags_q <= 3'b000;
        else
            flags_q <= flags_d;
    end
    assign flags = flags_q;
`endif

    // ---- iteration datapath stage ----
    always_ff @(posedge clk) begin
        rem_q <= rem_d;
        q_q   <= q_d;
        mb_q  <= mb_d;
        e_q   <= e_d;
        sr_q  <= sr_d;
        cnt_q <= cnt_d;
    end

    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign dataR = dataR_q;

endmodule

// File: tb/tb_alu_div.sv
// -----------------------------------------------------------------------------
// tb_alu_div
// Scoreboard bench for alu_div: expected {flags, dataR} is queued when an
// operation is accepted and compared when done pulses. Busy/done timing is
// checked cycle by cycle against the 28-cycle / 1-cycle latencies.
// -----------------------------------------------------------------------------
module tb_alu_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] dataA, dataB;
    logic        busy, done;
    logic [31:0] dataR;
`ifdef ALU_DIV_FLAGS_EN
    logic [2:0]  flags;
`endif

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [34:0] sb_q[$];

    always #5 clk = ~clk;

    alu_div dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .dataA (dataA),
        .dataB (dataB),
        .busy  (busy),
        .done  (done),
        .dataR (dataR)
`ifdef ALU_DIV_FLAGS_EN
        ,
        .flags (flags)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every done must match the oldest queued result.
    initial begin
        logic [34:0] e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", {31'b0, done}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("dataR", dataR, e[31:0]);
`ifdef ALU_DIV_FLAGS_EN
                    check("flags", {29'b0, flags}, {29'b0, e[34:32]});
`endif
                end
            end
        end
    end

    // Issue one operation and check busy/done every cycle until done.
    // now=1 drives start in the current (done) cycle for back-to-back issue.
    // poke>0 re-asserts start with other operands in cycle N+poke.
    task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic [2:0] f, input bit spec,
                         input bit now, input int poke);
        int lat;
        lat = spec ? 1 : 28;
        if (!now) @(negedge clk);
        dataA = a;
        dataB = b;
        start = 1'b1;
        @(posedge clk);
        sb_q.push_back({f, r});
        #1 start = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            check($sformatf("%s_busy_c%0d", name, k), {31'b0, busy},
                  (!spec && k < lat) ? 32'd1 : 32'd0);
            check($sformatf("%s_done_c%0d", name, k), {31'b0, done},
                  (k == lat) ? 32'd1 : 32'd0);
            if (poke > 0 && k == poke) begin
                dataA = 32'h3F80_0000;
                dataB = 32'h4040_0000;
                start = 1'b1;
            end
            if (poke > 0 && k == poke + 1)
                start = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        dataA = '0;
        dataB = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",  {31'b0, busy}, 32'd0);
        check("rst_done",  {31'b0, done}, 32'd0);
        check("rst_dataR", dataR, 32'h0);
`ifdef ALU_DIV_FLAGS_EN
        check("rst_flags", {29'b0, flags}, 32'd0);
`endif
        rst = 1'b0;

        do_op("div_6_2",    32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 3'b000, 0, 0, 0);
        do_op("div_1_3",    32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 3'b000, 0, 1, 0);
        do_op("div_2_3",    32'h4000_0000, 32'h4040_0000, 32'h3F2A_AAAB, 3'b000, 0, 1, 0);
        do_op("div_m6_2",   32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 3'b000, 0, 0, 0);
        do_op("div_1_1",    32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 3'b000, 0, 0, 0);
        do_op("divzero",    32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 3'b010, 1, 0, 0);
        do_op("zero_zero",  32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 3'b100, 1, 0, 0);
        do_op("nan_in",     32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 3'b100, 1, 1, 0);
        do_op("inf_inf",    32'hFF80_0000, 32'h7F80_0000, 32'h7FC0_0000, 3'b100, 1, 0, 0);
        do_op("inf_fin",    32'h7F80_0000, 32'hBF80_0000, 32'hFF80_0000, 3'b000, 1, 0, 0);
        do_op("fin_inf",    32'h3F80_0000, 32'h7F80_0000, 32'h0000_0000, 3'b000, 1, 0, 0);
        do_op("subn_flush", 32'h8040_0000, 32'h3F80_0000, 32'h8000_0000, 3'b000, 1, 0, 0);
        do_op("after_spec", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 3'b000, 0, 1, 0);
        do_op("overflow",   32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 3'b001, 0, 0, 0);
        do_op("underflow",  32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 3'b000, 0, 0, 0);
        do_op("ignored_st", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 3'b000, 0, 0, 5);

        repeat (3) begin
            @(negedge clk);
            check("idle_after_ignored", {31'b0, busy}, 32'd0);
        end
        check("dataR_held", dataR, 32'h4040_0000);

        // Abort: rst in cycle N+10 clears everything, no done follows.
        @(negedge clk);
        dataA = 32'h3F80_0000;
        dataB = 32'h4040_0000;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_busy_pre", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy",  {31'b0, busy}, 32'd0);
        check("abort_done",  {31'b0, done}, 32'd0);
        check("abort_dataR", dataR, 32'h0);
`ifdef ALU_DIV_FLAGS_EN
        check("abort_flags", {29'b0, flags}, 32'd0);
`endif
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("abort_no_done", {31'b0, done}, 32'd0);

        do_op("post_rst",   32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 3'b000, 0, 0, 0);

        repeat (4) @(negedge clk);
        check("sb_empty", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
